rr_arbiter_8: RTL and testbench
===============================

# rr_arbiter_8

Eight-way round-robin arbiter that selects one requester and presents its index as a 3-bit encoded grant, held until the winner releases it. It sits directly upstream of the 3-to-8 one-hot decoder: `grant_idx` drives the decoder's `encoded` input. The decoded vector, gated by `grant_valid`, forms the per-client grant/enable lines. A hold-time limit prevents any client from monopolising the grant.

## Interface
- `HOLD_LIMIT`, default 16: maximum cycles a grant may be held before forced release. 0 disables the limit. Legal range is 0..255.

- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `req`  in  8: request lines; bit i high means client i wants the grant. Level-sensitive.
- `done`  in  1: single-cycle release strobe from the currently granted client. Ignored when `grant_valid`=0.
- `grant_valid`  out  1: a grant is active; qualifies `grant_idx`.
- `grant_idx`  out  3: encoded index of the granted client. Feeds the one-hot decoder.
- `timeout`  out  1: one-cycle pulse marking a forced release by `HOLD_LIMIT`.

## Operation
- State machine has two states, IDLE and GRANT. Reset state is IDLE.
- Registered round-robin pointer `ptr[2:0]`, reset 0. Search order is ptr, ptr+1, …, 7, 0, …, ptr-1, with mod-8 wrap.
- IDLE:
  - If any `req` bit is high, latch the first requester in search order into `grant_idx`, set `grant_valid`, clear the hold counter, and go to GRANT.
  - If no `req` bit is high, stay in IDLE; `grant_idx` holds its last value.
- GRANT has three release conditions:
  - (a) `done`=1.
  - (b) `req[grant_idx]`=0, i.e. the request was withdrawn.
  - (c) `HOLD_LIMIT`≠0 and the hold counter equals `HOLD_LIMIT`-1 while neither (a) nor (b) holds.
- On release:
  - `grant_valid` goes to 0 and the state returns to IDLE.
  - `ptr` becomes `grant_idx`+1 mod 8, so 7 wraps to 0.
  - `timeout` pulses only for condition (c).
- While in GRANT and not releasing, the hold counter increments. It is 8 bits wide and saturates.
- Simultaneous events:
  - When (a) or (b) coincides with the limit cycle, it is a normal release and `timeout` stays 0.
  - Changes on other `req` bits during GRANT have no effect.
- `grant_idx` is stable for the entire time `grant_valid`=1.

## Timing
- Reset values: `grant_valid`=0, `grant_idx`=0, `timeout`=0, `ptr`=0, hold counter=0, state IDLE.
- Reset takes effect immediately, mid-grant included. Outputs drop without waiting for a clock edge.
- Arbitration latency is 1 cycle. With `req` sampled at edge N, `grant_valid` rises after edge N.
- Release latency is 1 cycle. When a release condition is sampled at edge N, `grant_valid`=0 after edge N.
- IDLE lasts at least one cycle between grants. The maximum back-to-back grant rate is one grant per 2 cycles plus hold time.
- A grant of duration `HOLD_LIMIT` L with no `done` keeps `grant_valid` high for exactly L cycles. `timeout` is high during the first IDLE cycle after that.
- All outputs are registered, with no combinational path from inputs to outputs.

## Test plan
- Reset during GRANT: after granting idx 3, assert `rst` mid-cycle.
  - Outputs go to 0 asynchronously.
  - After release, with `req`=8'h08 and `ptr` back at 0, the next grant is idx 3.
- Single requester: `req`=8'h20, with `done` pulsed 3 cycles after the grant.
  - `grant_idx`=5 and `grant_valid` high for exactly 3 cycles.
  - `ptr` becomes 6 afterwards.
- Rotation and wrap: `req`=8'h81 held constant, with `done` pulsed on each grant.
  - Grants alternate 0, 7, 0, 7.
  - After idx 7 releases, `ptr` wraps to 0.
- Fairness: `req`=8'hFF held constant, with `done` on the first grant cycle each time.
  - Grants run 0,1,2,…,7,0.
  - Each client is granted exactly once per 8 grants.
- Timeout: `HOLD_LIMIT`=4, `req`=8'h04, `done` never asserted.
  - `grant_valid` high for 4 cycles, then `timeout` pulses for 1 cycle.
  - Client 2 is re-granted after one IDLE cycle.
  - With `HOLD_LIMIT`=0, the grant persists for more than 300 cycles with no `timeout`.
- Withdrawal and coincidence, with `HOLD_LIMIT`=4:
  - Drop `req[grant_idx]` on cycle 2 of a grant: the grant releases the next cycle and `timeout`=0.
  - Pulse `done` on cycle 4 of a grant: the release is normal and `timeout`=0.

Source files
------------

// File: rtl/rr_arbiter_8.sv
// Eight-way round-robin arbiter with an encoded, registered grant that is held
// until done, request withdrawal, or the hold-time limit forces a release.
module rr_arbiter_8 #(
  parameter int HOLD_LIMIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  output logic       grant_valid,
  output logic [2:0] grant_idx,
  output logic       timeout
);

  localparam int         NUM_LANES = 8;
  localparam logic [7:0] LIM_M1    = (HOLD_LIMIT == 0) ? 8'd0 : 8'(HOLD_LIMIT - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state, state_nxt;
  logic [2:0] ptr, ptr_nxt, idx_nxt, pick;
  logic [7:0] cnt, cnt_nxt;
  logic       tmo_nxt, rel_a, rel_b, rel_c;

  // Scan from the farthest offset down so the nearest requester to ptr wins.
  always_comb begin
    pick = ptr;
    for (int k = NUM_LANES - 1; k >= 0; k--)
      if (req[ptr + 3'(k)]) pick = ptr + 3'(k);
  end

  assign rel_a = done;
  assign rel_b = !req[grant_idx];
  assign rel_c = (HOLD_LIMIT != 0) && (cnt == LIM_M1);

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    idx_nxt   = grant_idx;
    cnt_nxt   = cnt;
    tmo_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          idx_nxt   = pick;
          cnt_nxt   = 8'd0;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (rel_a || rel_b || rel_c) begin
          state_nxt = IDLE;
          ptr_nxt   = grant_idx + 3'd1;
          // A coincident done/withdrawal takes precedence over the limit.
          tmo_nxt   = !rel_a && !rel_b;
        end else if (cnt != 8'hFF) begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= 3'd0;
      cnt         <= 8'd0;
      grant_idx   <= 3'd0;
      grant_valid <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state       <= state_nxt;
      ptr         <= ptr_nxt;
      cnt         <= cnt_nxt;
      grant_idx   <= idx_nxt;
      grant_valid <= (state_nxt == GRANT);
      timeout     <= tmo_nxt;
    end
  end

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed bench for rr_arbiter_8: three instances (default limit, limit 4,
// limit disabled) checked cycle by cycle against a queue of expected outputs.
module tb_rr_arbiter_8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] reqa = '0, reqb = '0, reqc = '0;
  logic       donea = 1'b0, doneb = 1'b0, donec = 1'b0;
  logic       va, vb, vc, ta, tb, tc;
  logic [2:0] ia, ib, ic;

  always #5 clk = ~clk;

  rr_arbiter_8 u_a (.clk(clk), .rst(rst), .req(reqa), .done(donea),
                    .grant_valid(va), .grant_idx(ia), .timeout(ta));
  rr_arbiter_8 #(.HOLD_LIMIT(4)) u_b (.clk(clk), .rst(rst), .req(reqb), .done(doneb),
                    .grant_valid(vb), .grant_idx(ib), .timeout(tb));
  rr_arbiter_8 #(.HOLD_LIMIT(0)) u_c (.clk(clk), .rst(rst), .req(reqc), .done(donec),
                    .grant_valid(vc), .grant_idx(ic), .timeout(tc));

  // Observation word: {timeout, grant_valid, grant_idx}
  wire [4:0] oa = {ta, va, ia};
  wire [4:0] ob = {tb, vb, ib};
  wire [4:0] oc = {tc, vc, ic};

  typedef struct {
    string      tag;
    logic [4:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   hits[8];

  function automatic logic [4:0] g(input int idx);
    return {1'b0, 1'b1, 3'(idx)};
  endfunction

  function automatic logic [4:0] idle(input int idx, input logic tmo);
    return {tmo, 1'b0, 3'(idx)};
  endfunction

  task automatic push(input string tag, input logic [4:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [4:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: got %b want <entry>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s: got %b want %b", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [4:0] seen;
    logic       bad;
    int         seq[$];

    // Reset state on all three instances
    #2;
    push("reset_a", 5'b0); chk(oa);
    push("reset_b", 5'b0); chk(ob);
    push("reset_c", 5'b0); chk(oc);
    tick();
    rst = 1'b0;

    // Reset mid-grant
    reqa = 8'h08;
    push("pre_rst_grant3", g(3)); tick(); chk(oa);
    #3 rst = 1'b1;
    #1 push("async_rst", 5'b0); chk(oa);
    tick();
    push("rst_held", 5'b0); chk(oa);
    rst = 1'b0;
    push("post_rst_grant3", g(3)); tick(); chk(oa);
    donea = 1'b1;
    push("post_rst_rel", idle(3, 1'b0)); tick(); chk(oa);
    donea = 1'b0; reqa = 8'h00;

    // Single requester, done in third grant cycle; ptr then 6
    reqa = 8'h20;
    push("single_c1", g(5)); tick(); chk(oa);
    push("single_c2", g(5)); tick(); chk(oa);
    push("single_c3", g(5)); tick(); chk(oa);
    donea = 1'b1;
    push("single_rel", idle(5, 1'b0)); tick(); chk(oa);
    donea = 1'b0; reqa = 8'h60;
    push("ptr_is_6", g(6)); tick(); chk(oa);
    donea = 1'b1;
    push("ptr6_rel", idle(6, 1'b0)); tick(); chk(oa);
    donea = 1'b0;

    // Rotation with wrap: ptr is 7 here, so 7,0,7,0,7 leaves ptr at 0
    reqa = 8'h81;
    seq = '{7, 0, 7, 0, 7};
    foreach (seq[n]) begin
      push($sformatf("rot_grant%0d", n), g(seq[n])); tick(); chk(oa);
      donea = 1'b1;
      push($sformatf("rot_rel%0d", n), idle(seq[n], 1'b0)); tick(); chk(oa);
      donea = 1'b0;
    end

    // Fairness over all eight clients
    reqa = 8'hFF;
    for (int n = 0; n < 9; n++) begin
      push($sformatf("fair_grant%0d", n), g(n % 8)); tick(); chk(oa);
      if (n < 8 && va) hits[ia]++;
      donea = 1'b1;
      push($sformatf("fair_rel%0d", n), idle(n % 8, 1'b0)); tick(); chk(oa);
      donea = 1'b0;
    end
    for (int k = 0; k < 8; k++) begin
      push($sformatf("fair_count%0d", k), 5'd1); chk(5'(hits[k]));
    end
    reqa = 8'h00;

    // Timeout with HOLD_LIMIT=4
    reqb = 8'h04;
    for (int n = 1; n <= 4; n++) begin
      push($sformatf("tmo_c%0d", n), g(2)); tick(); chk(ob);
    end
    push("tmo_pulse", idle(2, 1'b1)); tick(); chk(ob);
    push("tmo_regrant", g(2)); tick(); chk(ob);

    // Withdrawal on cycle 2
    push("wd_c2", g(2)); tick(); chk(ob);
    reqb = 8'h00;
    push("wd_rel", idle(2, 1'b0)); tick(); chk(ob);
    push("wd_idle", idle(2, 1'b0)); tick(); chk(ob);

    // done coinciding with the limit cycle
    reqb = 8'h04;
    for (int n = 1; n <= 4; n++) begin
      push($sformatf("coin_c%0d", n), g(2)); tick(); chk(ob);
    end
    doneb = 1'b1;
    push("coin_rel", idle(2, 1'b0)); tick(); chk(ob);
    doneb = 1'b0; reqb = 8'h00;

    // Limit disabled: grant persists past 300 cycles
    reqc = 8'h04;
    push("nolim_first", g(2)); tick(); chk(oc);
    bad = 1'b0;
    seen = oc;
    for (int n = 0; n < 310; n++) begin
      tick();
      if (!bad) seen = oc;
      if (oc !== g(2)) bad = 1'b1;
    end
    push("nolim_hold310", g(2)); chk(seen);
    reqc = 8'h00;
    push("nolim_rel", idle(2, 1'b0)); tick(); chk(oc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
